// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath selects
// and enables, flags unsupported opcodes and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic [3:0]  state_dbg,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    ALUWB  = 4'd7,
    EXECI  = 4'd8,
    BEQ    = 4'd9,
    ERROR  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  // State register; reset aborts any in-flight instruction back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; memory states hold until the memory completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_ADDI:      state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = ERROR;
        endcase
      end
      MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (mem_ready) state_d = FETCH;
      EXECR:  state_d = ALUWB;
      EXECI:  state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      BEQ:    state_d = FETCH;
      ERROR:  state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // Retire on the final cycle of each instruction; illegal latches on ERROR entry.
  always_comb begin
    retire    = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                ((state_q == MEMWR) && mem_ready);
    retired_d = retire ? retired_q + 32'd1 : retired_q;
    illegal_d = illegal_q || (state_d == ERROR);
  end

  // Status registers: retired-instruction counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode: Moore selects, Mealy fetch/branch PC and IR loads.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero;
      end
      default: ;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign illegal   = illegal_q;
  assign state_dbg = state_q;
  assign retired   = retired_q;

endmodule
